// File: rtl/seg7_pkg.sv
// Shared types, constants and hex decode table for the
// 2-digit 7-segment display arbiter.
package seg7_pkg;

  typedef enum logic [1:0] {
    S_D0   = 2'd0,
    S_BLK0 = 2'd1,
    S_D1   = 2'd2,
    S_BLK1 = 2'd3
  } scan_e;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_A    = 2'd1,
    ARB_B    = 2'd2
  } arb_e;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [1:0] AN_OFF    = 2'b11;

  // Active-low segments, bit order {g,f,e,d,c,b,a}
  function automatic logic [6:0] hex_to_seg(
    input logic [3:0] d
  );
    logic [6:0] s;
    s = SEG_BLANK;
    unique case (d)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      4'hF: s = 7'b0001110;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg7_disp_arbiter_hex_dec.sv
// Combinational hex digit to active-low 7-segment decoder.
// Ports: hex (4-bit digit in), seg (7-bit active-low out).
module seg7_hex_dec
  import seg7_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  always_comb begin
    seg = hex_to_seg(hex);
  end

endmodule

// File: rtl/seg7_disp_arbiter.sv
// Round-robin owner of a 2-digit muxed 7-seg display.
// Ports: clk, rst_n (sync, low), req[1:0] (B,A),
// a/b_digit0/1 (hex), gnt (one-hot owner), SEG, AN.
// Optional: SEG7_LZB_EN blanks a leading zero on digit1.
module seg7_disp_arbiter
  import seg7_pkg::*;
#(
  parameter int CLK_DIV   = 50000,
  parameter int BLANK_CYC = 2,
  parameter int HOLD_CYC  = 1000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic [3:0] a_digit0,
  input  logic [3:0] a_digit1,
  input  logic [3:0] b_digit0,
  input  logic [3:0] b_digit1,
  output logic [1:0] gnt,
  output logic [6:0] SEG,
  output logic [1:0] AN
);

  localparam int DIV_W  = $clog2(CLK_DIV + BLANK_CYC + 1);
  localparam int HOLD_W = $clog2(HOLD_CYC + 1);

  localparam logic [DIV_W-1:0] DIV_MAX =
    DIV_W'(CLK_DIV - 1);
  // Unreachable when BLANK_CYC is 0 (blank states skipped)
  localparam logic [DIV_W-1:0] BLK_MAX =
    DIV_W'(BLANK_CYC - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX =
    HOLD_W'(HOLD_CYC - 1);
  localparam bit NO_BLANK = (BLANK_CYC == 0);

  arb_e              arb_q, arb_d;
  logic [1:0]        gnt_q, gnt_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              prio_b_q, prio_b_d;

  scan_e             scan_q, scan_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [3:0]        snap_q, snap_d;
  logic              snap_on_q, snap_on_d;
  logic [6:0]        seg_q, seg_d;
  logic [1:0]        an_q, an_d;

  logic [6:0]        dec_seg;
  logic              lz_blank;

  seg7_hex_dec u_dec (
    .hex (snap_q),
    .seg (dec_seg)
  );

`ifdef SEG7_LZB_EN
  assign lz_blank = (snap_q == 4'h0);
`else
  assign lz_blank = 1'b0;
`endif

  // Arbiter next state
  always_comb begin
    arb_d    = arb_q;
    prio_b_d = prio_b_q;
    hold_d   = (hold_q == HOLD_MAX) ? hold_q
                                    : hold_q + 1'b1;
    unique case (arb_q)
      ARB_IDLE: begin
        if (req == 2'b11)
          arb_d = prio_b_q ? ARB_B : ARB_A;
        else if (req[0])
          arb_d = ARB_A;
        else if (req[1])
          arb_d = ARB_B;
      end
      ARB_A: begin
        if (!req[0])
          arb_d = req[1] ? ARB_B : ARB_IDLE;
        else if (req[1] && hold_q == HOLD_MAX)
          arb_d = ARB_B;
      end
      ARB_B: begin
        if (!req[1])
          arb_d = req[0] ? ARB_A : ARB_IDLE;
        else if (req[0] && hold_q == HOLD_MAX)
          arb_d = ARB_A;
      end
      default: arb_d = ARB_IDLE;
    endcase
    if (arb_d != arb_q)
      hold_d = '0;
    // Favour the side not served most recently
    if (arb_d == ARB_A)
      prio_b_d = 1'b1;
    else if (arb_d == ARB_B)
      prio_b_d = 1'b0;
    gnt_d = {arb_d == ARB_B, arb_d == ARB_A};
  end

  // Scan sequencer and digit snapshot
  always_comb begin
    scan_d    = scan_q;
    div_d     = div_q + 1'b1;
    snap_d    = snap_q;
    snap_on_d = snap_on_q;
    unique case (scan_q)
      S_D0: begin
        if (div_q == DIV_MAX)
          scan_d = NO_BLANK ? S_D1 : S_BLK0;
      end
      S_BLK0: begin
        if (div_q == BLK_MAX)
          scan_d = S_D1;
      end
      S_D1: begin
        if (div_q == DIV_MAX)
          scan_d = NO_BLANK ? S_D0 : S_BLK1;
      end
      S_BLK1: begin
        if (div_q == BLK_MAX)
          scan_d = S_D0;
      end
      default: scan_d = S_D0;
    endcase
    if (scan_d != scan_q)
      div_d = '0;
    // Latch the owner's digit once per phase so a
    // grant change never tears a lit digit
    if (scan_d != scan_q && scan_d == S_D0) begin
      snap_d    = gnt_q[1] ? b_digit0 : a_digit0;
      snap_on_d = |gnt_q;
    end
    if (scan_d != scan_q && scan_d == S_D1) begin
      snap_d    = gnt_q[1] ? b_digit1 : a_digit1;
      snap_on_d = |gnt_q;
    end
  end

  // Pin drive, one cycle behind scan state
  always_comb begin
    an_d  = AN_OFF;
    seg_d = SEG_BLANK;
    unique case (scan_q)
      S_D0: begin
        if (snap_on_q) begin
          an_d  = 2'b10;
          seg_d = dec_seg;
        end
      end
      S_D1: begin
        if (snap_on_q && !lz_blank) begin
          an_d  = 2'b01;
          seg_d = dec_seg;
        end
      end
      default: begin
        an_d  = AN_OFF;
        seg_d = SEG_BLANK;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      arb_q     <= ARB_IDLE;
      gnt_q     <= 2'b00;
      hold_q    <= '0;
      prio_b_q  <= 1'b0;
      scan_q    <= S_D0;
      div_q     <= '0;
      snap_q    <= 4'h0;
      snap_on_q <= 1'b0;
      seg_q     <= SEG_BLANK;
      an_q      <= AN_OFF;
    end else begin
      arb_q     <= arb_d;
      gnt_q     <= gnt_d;
      hold_q    <= hold_d;
      prio_b_q  <= prio_b_d;
      scan_q    <= scan_d;
      div_q     <= div_d;
      snap_q    <= snap_d;
      snap_on_q <= snap_on_d;
      seg_q     <= seg_d;
      an_q      <= an_d;
    end
  end

  assign gnt = gnt_q;
  assign SEG = seg_q;
  assign AN  = an_q;

endmodule

// File: tb/tb_seg7_disp_arbiter.sv
// Scoreboard bench for seg7_disp_arbiter with
// CLK_DIV=4, BLANK_CYC=1, HOLD_CYC=8.
module tb_seg7_disp_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] req;
  logic [3:0] a_digit0, a_digit1;
  logic [3:0] b_digit0, b_digit1;
  logic [1:0] gnt;
  logic [6:0] seg;
  logic [1:0] an;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  localparam int K_GNT = 0;
  localparam int K_AN  = 1;
  localparam int K_SEG = 2;

  localparam logic [6:0] BLK = 7'b1111111;

  typedef struct {
    int         cyc;
    int         kind;
    logic [6:0] val;
  } exp_t;

  exp_t exp_q[$];

  seg7_disp_arbiter #(
    .CLK_DIV   (4),
    .BLANK_CYC (1),
    .HOLD_CYC  (8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .a_digit0 (a_digit0),
    .a_digit1 (a_digit1),
    .b_digit0 (b_digit0),
    .b_digit1 (b_digit1),
    .gnt      (gnt),
    .SEG      (seg),
    .AN       (an)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(
    input string      tag,
    input logic [6:0] got,
    input logic [6:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%b expected=%b",
               tag, got, exp);
    end
  endtask

  task automatic push(
    input int c0, input int c1,
    input int kind, input logic [6:0] v
  );
    for (int c = c0; c <= c1; c++) begin
      exp_t e;
      e.cyc  = c;
      e.kind = kind;
      e.val  = v;
      exp_q.push_back(e);
    end
  endtask

  task automatic exp_gnt(
    input int c0, input int c1,
    input logic [1:0] g
  );
    push(c0, c1, K_GNT, {5'b0, g});
  endtask

  task automatic exp_disp(
    input int c0, input int c1,
    input logic [1:0] a, input logic [6:0] s
  );
    push(c0, c1, K_AN, {5'b0, a});
    push(c0, c1, K_SEG, s);
  endtask

  task automatic step_to(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Pop and compare every entry due this cycle
  always @(negedge clk) begin
    for (int i = exp_q.size() - 1; i >= 0; i--) begin
      if (exp_q[i].cyc == cyc) begin
        unique case (exp_q[i].kind)
          K_GNT: chk($sformatf("gnt@%0d", cyc),
                     {5'b0, gnt}, exp_q[i].val);
          K_AN:  chk($sformatf("an@%0d", cyc),
                     {5'b0, an}, exp_q[i].val);
          default:
                 chk($sformatf("seg@%0d", cyc),
                     seg, exp_q[i].val);
        endcase
        exp_q.delete(i);
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    rst_n    = 1'b0;
    req      = 2'b00;
    a_digit0 = 4'h0;
    a_digit1 = 4'h0;
    b_digit0 = 4'h0;
    b_digit1 = 4'h0;

    // Reset on edges 1..3, idle for 3 scans
    exp_gnt(1, 33, 2'b00);
    exp_disp(1, 33, 2'b11, BLK);
    step_to(3);
    rst_n = 1'b1;

    // Both request from idle: A first, B after hold
    step_to(34);
    a_digit0 = 4'h3;
    a_digit1 = 4'h7;
    b_digit0 = 4'h1;
    b_digit1 = 4'h9;
    req      = 2'b11;
    exp_gnt(34, 34, 2'b00);
    exp_gnt(35, 42, 2'b01);
    exp_gnt(43, 58, 2'b10);
    exp_disp(34, 38, 2'b11, BLK);
    exp_disp(39, 42, 2'b01, 7'b1111000);
    exp_disp(43, 43, 2'b11, BLK);
    exp_disp(44, 47, 2'b10, 7'b0110000);
    exp_disp(48, 48, 2'b11, BLK);
    exp_disp(49, 52, 2'b01, 7'b0010000);
    exp_disp(53, 53, 2'b11, BLK);
    exp_disp(54, 57, 2'b10, 7'b1111001);
    exp_disp(58, 58, 2'b11, BLK);
    step_to(43);
    req = 2'b10;

    // Idle, then A alone, then swap A->B mid-hold
    step_to(58);
    req = 2'b00;
    exp_gnt(59, 61, 2'b00);
    exp_gnt(62, 64, 2'b01);
    exp_gnt(65, 70, 2'b10);
    exp_disp(59, 62, 2'b01, 7'b0010000);
    exp_disp(63, 63, 2'b11, BLK);
    exp_disp(64, 67, 2'b10, 7'b0110000);
    exp_disp(68, 68, 2'b11, BLK);
    exp_disp(69, 70, 2'b01, 7'b0010000);
    step_to(61);
    req = 2'b01;
    step_to(64);
    req = 2'b10;

    // Reset in the middle of B's digit1 phase
    step_to(70);
    rst_n = 1'b0;
    exp_gnt(71, 71, 2'b00);
    exp_disp(71, 71, 2'b11, BLK);
    step_to(71);
    rst_n = 1'b1;
    exp_gnt(72, 86, 2'b10);
    exp_disp(72, 76, 2'b11, BLK);
    exp_disp(77, 80, 2'b01, 7'b0010000);
    exp_disp(81, 81, 2'b11, BLK);
    exp_disp(82, 85, 2'b10, 7'b1111001);
    exp_disp(86, 86, 2'b11, BLK);

    // Leading zero on A's digit1
    step_to(86);
    a_digit0 = 4'h5;
    a_digit1 = 4'h0;
    req      = 2'b01;
    exp_gnt(87, 101, 2'b01);
    exp_disp(87, 90, 2'b01, 7'b0010000);
    exp_disp(91, 91, 2'b11, BLK);
    exp_disp(92, 95, 2'b10, 7'b0010010);
    exp_disp(96, 96, 2'b11, BLK);
`ifdef SEG7_LZB_EN
    exp_disp(97, 100, 2'b11, BLK);
`else
    exp_disp(97, 100, 2'b01, 7'b1000000);
`endif
    exp_disp(101, 101, 2'b11, BLK);

    step_to(103);
    chk("sb_drained",
        (exp_q.size() == 0) ? 7'd0 : 7'd1, 7'd0);
    $display("TB_RESULT checks=%0d failures=%0d",
             n_chk, n_fail);
    $finish;
  end

endmodule
